// File: rtl/bitstream_reader.sv
// MSB-first bit window over a byte-packed word stream, consumed by pop/pad requests.
// Optional zero-bit check on pad discards: define BITSTREAM_READER_ALIGN_CHECK_EN.
module bitstream_reader #(
  parameter int PARSER_DATA_WIDTH = 32,
  parameter int IN_WIDTH          = 32,
  parameter int BUF_WIDTH         = 96
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [IN_WIDTH-1:0]                  in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [PARSER_DATA_WIDTH-1:0]         data_out,
  output logic                                 data_valid,
  output logic [$clog2(BUF_WIDTH+1)-1:0]       fill,
  input  logic                                 pop,
  input  logic [$clog2(PARSER_DATA_WIDTH):0]   pop_len,
  input  logic                                 pad,
  output logic [31:0]                          bit_pos,
  output logic                                 done,
  output logic                                 underrun,
  output logic                                 align_err
);
  localparam int FW = $clog2(BUF_WIDTH+1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [31:0]          bit_pos_q, bit_pos_d;
  logic                 in_ready_q, in_ready_d;
  logic                 data_valid_q, data_valid_d;
  logic                 underrun_q, underrun_d;

  logic [FW-1:0]        req_pop, req_total, rem, fill_rem;
  logic [2:0]           pos_after_pop, k;
  logic                 consume, hs;
  logic [BUF_WIDTH-1:0] ext;

`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
  logic                 align_err_q, align_err_d;
  logic [BUF_WIDTH-1:0] peek;
  logic [7:0]           mask;
`endif

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    fill_d        = fill_q;
    bit_pos_d     = bit_pos_q;
    underrun_d    = underrun_q;
    req_pop       = pop ? FW'(pop_len) : '0;
    pos_after_pop = bit_pos_q[2:0] + req_pop[2:0];
    // Pad distance measured from the post-pop position: (8 - pos) mod 8.
    k             = pad ? 3'(3'd0 - pos_after_pop) : 3'd0;
    req_total     = req_pop + FW'(k);
    consume       = (state_q != S_IDLE) && (pop || pad);
    rem           = '0;
    if (consume) rem = (req_total > fill_q) ? fill_q : req_total;
    fill_rem      = fill_q - rem;
    hs            = in_valid && in_ready_q && (state_q == S_RUN);
    ext           = {in_data, {(BUF_WIDTH-IN_WIDTH){1'b0}}};
`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
    align_err_d   = align_err_q;
    peek          = buf_q << req_pop;
    mask          = ~(8'hFF >> k);
    if (consume && pad && |(peek[BUF_WIDTH-1 -: 8] & mask)) align_err_d = 1'b1;
`endif

    if (consume && (!data_valid_q || req_total > fill_q)) underrun_d = 1'b1;
    buf_d     = buf_q << rem;
    fill_d    = fill_rem;
    bit_pos_d = bit_pos_q + 32'(rem);

    // New word lands directly below whatever survives this cycle's removal.
    if (hs) begin
      buf_d  = buf_d | (ext >> fill_rem);
      fill_d = fill_rem + FW'(IN_WIDTH);
      if (in_last) state_d = S_DRAIN;
    end
    if (state_q == S_DRAIN && fill_q == '0) state_d = S_DONE;

    if (start) begin
      state_d    = S_RUN;
      buf_d      = '0;
      fill_d     = '0;
      bit_pos_d  = '0;
      underrun_d = 1'b0;
`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
      align_err_d = 1'b0;
`endif
    end

    in_ready_d = (state_d == S_RUN) && (fill_d <= FW'(BUF_WIDTH - IN_WIDTH));
    case (state_d)
      S_RUN:   data_valid_d = fill_d >= FW'(PARSER_DATA_WIDTH);
      S_DRAIN: data_valid_d = fill_d != '0;
      default: data_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_q        <= '0;
      fill_q       <= '0;
      bit_pos_q    <= '0;
      in_ready_q   <= 1'b0;
      data_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
      align_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      bit_pos_q    <= bit_pos_d;
      in_ready_q   <= in_ready_d;
      data_valid_q <= data_valid_d;
      underrun_q   <= underrun_d;
`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
      align_err_q  <= align_err_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign data_out   = buf_q[BUF_WIDTH-1 -: PARSER_DATA_WIDTH];
  assign data_valid = data_valid_q;
  assign fill       = fill_q;
  assign bit_pos    = bit_pos_q;
  assign done       = (state_q == S_DONE);
  assign underrun   = underrun_q;
`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
  assign align_err  = align_err_q;
`else
  assign align_err  = 1'b0;
`endif
endmodule

// File: tb/tb_bitstream_reader.sv
// Self-checking bench for bitstream_reader: directed scenarios plus random traffic vs a bit-queue model.
module tb_bitstream_reader;
  logic        clk, rst, start, in_valid, in_last, in_ready, data_valid, pop, pad;
  logic        done, underrun, align_err;
  logic [31:0] in_data, data_out, bit_pos;
  logic [6:0]  fill;
  logic [5:0]  pop_len;

  int errors = 0;
  int checks = 0;

  bitstream_reader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .data_out(data_out), .data_valid(data_valid),
    .fill(fill), .pop(pop), .pop_len(pop_len), .pad(pad), .bit_pos(bit_pos),
    .done(done), .underrun(underrun), .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stream states 0 idle, 1 run, 2 drain, 3 done; buffer is a queue of bits.
  int          mst;
  bit          mq[$];
  logic [31:0] mpos;
  bit          mrdy, mdv, mund, mal;

`ifdef BITSTREAM_READER_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  function automatic logic [31:0] exp_out();
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) if (i < mq.size()) r[31-i] = mq[i];
    return r;
  endfunction

  task automatic tick();
    int ns, pre, req, kk, tot, n;
    ns  = mst;
    pre = mq.size();
    if (rst) begin
      mq.delete(); mst = 0; mpos = 0; mund = 0; mal = 0; mrdy = 0; mdv = 0;
    end else begin
      if (start) begin
        mq.delete(); ns = 1; mpos = 0; mund = 0; mal = 0;
      end else begin
        if (mst != 0 && (pop || pad)) begin
          req = pop ? int'(pop_len) : 0;
          kk  = pad ? (8 - ((int'(mpos[2:0]) + req) % 8)) % 8 : 0;
          tot = req + kk;
          if (!mdv || tot > mq.size()) mund = 1;
          if (ALIGN_EN)
            for (int i = req; i < req + kk; i++) if (i < mq.size() && mq[i]) mal = 1;
          n = (tot > mq.size()) ? mq.size() : tot;
          repeat (n) void'(mq.pop_front());
          mpos = mpos + 32'(n);
        end
        if (mst == 1 && in_valid && mrdy) begin
          for (int i = 31; i >= 0; i--) mq.push_back(in_data[i]);
          if (in_last) ns = 2;
        end
        if (mst == 2 && pre == 0) ns = 3;
      end
      mst  = ns;
      mrdy = (mst == 1) && (mq.size() <= 64);
      mdv  = (mst == 1) ? (mq.size() >= 32) : (mst == 2) ? (mq.size() > 0) : 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; in_valid = 0; in_last = 0; in_data = '0; pop = 0; pop_len = '0; pad = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    in_valid = 1; in_data = w; in_last = last; tick(); in_valid = 0; in_last = 0;
  endtask

  task automatic do_pop(input int len, input logic p);
    pop = (len >= 0); pop_len = (len >= 0) ? 6'(len) : '0; pad = p; tick();
    pop = 0; pop_len = '0; pad = 0;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1; tick(); tick(); rst = 0;
    checks++; if (data_out !== 32'h0 || fill !== 7'd0 || bit_pos !== 32'h0) begin
      errors++; $display("FAIL reset_data: data_out=%h fill=%0d bit_pos=%0d want 0/0/0", data_out, fill, bit_pos); end
    checks++; if ({in_ready, data_valid, done, underrun, align_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {in_ready, data_valid, done, underrun, align_err}); end
    do_pop(4, 1);
    checks++; if (underrun !== 1'b0 || bit_pos !== 32'h0) begin
      errors++; $display("FAIL idle_pop_ignored: underrun=%b bit_pos=%0d want 0/0", underrun, bit_pos); end
  endtask

  task automatic test_pop_pad();
    do_start(); send(32'hA5C3_0F01, 1);
    checks++; if (data_valid !== 1'b1 || fill !== 7'd32 || data_out !== 32'hA5C30F01) begin
      errors++; $display("FAIL first_word: dv=%b fill=%0d out=%h want 1/32/a5c30f01", data_valid, fill, data_out); end
    do_pop(4, 0);
    checks++; if (data_out !== 32'h5C30F010 || fill !== 7'd28 || bit_pos !== 32'd4) begin
      errors++; $display("FAIL pop4: out=%h fill=%0d pos=%0d want 5c30f010/28/4", data_out, fill, bit_pos); end
    do_start(); send(32'hA5C3_0F01, 1);
    do_pop(3, 0); do_pop(-1, 1);
    checks++; if (bit_pos !== 32'd8 || data_out !== 32'hC30F0100) begin
      errors++; $display("FAIL pad_k5: pos=%0d out=%h want 8/c30f0100", bit_pos, data_out); end
    checks++; if (align_err !== ALIGN_EN) begin
      errors++; $display("FAIL pad_align_err: got %b want %b", align_err, ALIGN_EN); end
    do_pop(-1, 1);
    checks++; if (bit_pos !== 32'd8 || data_out !== 32'hC30F0100 || fill !== 7'd24) begin
      errors++; $display("FAIL pad_aligned_noop: pos=%0d out=%h fill=%0d want 8/c30f0100/24", bit_pos, data_out, fill); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int acc = 0;
    words[0] = 32'h11111111; words[1] = 32'h22222222; words[2] = 32'h33333333;
    do_start();
    for (int c = 0; c < 20 && acc < 3; c++) begin
      in_valid = 1; in_data = words[acc];
      if (mrdy) acc++;
      tick();
    end
    in_data = 32'h44444444;
    checks++; if (acc != 3 || in_ready !== 1'b0 || fill !== 7'd96) begin
      errors++; $display("FAIL backpressure: accepted=%0d ready=%b fill=%0d want 3/0/96", acc, in_ready, fill); end
    tick(); in_valid = 0;
    checks++; if (data_out !== 32'h11111111 || fill !== 7'd96) begin
      errors++; $display("FAIL b2b_head: out=%h fill=%0d want 11111111/96", data_out, fill); end
    do_pop(32, 0);
    checks++; if (in_ready !== 1'b1 || data_out !== 32'h22222222 || fill !== 7'd64) begin
      errors++; $display("FAIL b2b_reready: ready=%b out=%h fill=%0d want 1/22222222/64", in_ready, data_out, fill); end
  endtask

  task automatic test_pop_pad_same();
    do_start(); send(32'hF812_3456, 0);
    do_pop(5, 1);
    checks++; if (bit_pos !== 32'd8 || fill !== 7'd24 || data_out !== 32'h12345600) begin
      errors++; $display("FAIL pop5_pad: pos=%0d fill=%0d out=%h want 8/24/12345600", bit_pos, fill, data_out); end
    checks++; if (align_err !== 1'b0 || underrun !== 1'b0 || data_valid !== 1'b0) begin
      errors++; $display("FAIL pop5_pad_flags: al=%b un=%b dv=%b want 0/0/0", align_err, underrun, data_valid); end
  endtask

  task automatic test_underrun_done();
    do_start(); send(32'hDEAD_BEEF, 1);
    do_pop(32, 0);
    checks++; if (fill !== 7'd0 || bit_pos !== 32'd32 || underrun !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL drain_empty: fill=%0d pos=%0d un=%b done=%b want 0/32/0/0", fill, bit_pos, underrun, done); end
    do_pop(1, 0);
    checks++; if (underrun !== 1'b1 || bit_pos !== 32'd32 || done !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL underrun_done: un=%b pos=%0d done=%b dv=%b want 1/32/1/0", underrun, bit_pos, done, data_valid); end
  endtask

  task automatic test_start_override();
    do_start(); send(32'h0123_4567, 0); send(32'h89AB_CDEF, 0);
    do_pop(24, 0);
    checks++; if (fill !== 7'd40 || bit_pos !== 32'd24) begin
      errors++; $display("FAIL pre_start_fill: fill=%0d pos=%0d want 40/24", fill, bit_pos); end
    do_pop(33, 0);
    start = 1; pop = 1; pop_len = 6'd8; tick(); start = 0; pop = 0;
    checks++; if (fill !== 7'd0 || bit_pos !== 32'd0 || underrun !== 1'b0 || in_ready !== 1'b1 || data_valid !== 1'b0) begin
      errors++; $display("FAIL start_override: fill=%0d pos=%0d un=%b rdy=%b dv=%b want 0/0/0/1/0", fill, bit_pos, underrun, in_ready, data_valid); end
    send(32'hCAFE_F00D, 0);
    rst = 1; tick(); rst = 0;
    checks++; if ({in_ready, data_valid, done, underrun, align_err} !== 5'b0 || fill !== 7'd0 || bit_pos !== 32'h0 || data_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid: flags=%b fill=%0d pos=%0d out=%h want 0", {in_ready, data_valid, done, underrun, align_err}, fill, bit_pos, data_out); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      idle_in();
      if (c % 600 == 5 || $urandom_range(0, 199) == 0) start = 1;
      in_valid = $urandom_range(0, 1);
      in_data  = $urandom;
      in_last  = ($urandom_range(0, 15) == 0);
      if (mdv || $urandom_range(0, 29) == 0) begin
        pop     = $urandom_range(0, 1);
        pop_len = 6'($urandom_range(0, 32));
        pad     = ($urandom_range(0, 3) == 0);
      end
      tick();
      checks++; if (data_out !== exp_out() || fill !== 7'(mq.size()) || bit_pos !== mpos) begin
        errors++; $display("FAIL rnd_data c=%0d: out=%h fill=%0d pos=%0d want %h/%0d/%0d", c, data_out, fill, bit_pos, exp_out(), mq.size(), mpos); end
      checks++; if ({in_ready, data_valid, done, underrun, align_err} !== {mrdy, mdv, mst == 3, mund, mal}) begin
        errors++; $display("FAIL rnd_flags c=%0d: rdy/dv/done/un/al=%b want %b", c, {in_ready, data_valid, done, underrun, align_err}, {mrdy, mdv, mst == 3, mund, mal}); end
    end
  endtask

  initial begin
    rst = 1; idle_in();
    mst = 0; mpos = 0; mrdy = 0; mdv = 0; mund = 0; mal = 0;
    test_reset();
    test_pop_pad();
    test_back_to_back();
    test_pop_pad_same();
    test_underrun_done();
    test_start_override();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
